// File: rtl/proc_sched_arbiter.sv
// proc_sched_arbiter
//   Shares one output register among NPROC requesting processes. One
//   process at a time holds a round-robin grant. When the holder strobes
//   done, its result is latched into o_out and o_out_valid pulses. A holder
//   that drops its request is abandoned quietly. A holder that stalls for
//   TIMEOUT cycles in BUSY is aborted, and o_err pulses.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_req        per-process request level, held until done
//   i_req_data   process i result at bits [i*DW +: DW]
//   i_done       per-process one-cycle result-valid strobe
//   o_gnt        one-hot grant, registered
//   o_out        shared output register
//   o_out_valid  one-cycle pulse when o_out has just been updated
//   o_err        one-cycle pulse on timeout abort
//   o_busy       high whenever the FSM is not in IDLE
//
// States
//   state   | meaning
//   IDLE    | no grant; round-robin scan of i_req starting after r_last
//   GRANT   | grant issued; timer cleared; done from winner already honoured
//   BUSY    | waiting for done / request drop / timeout of the winner
//   RELEASE | grant removed; o_out_valid or o_err visible; r_last updated
module proc_sched_arbiter #(
    parameter int NPROC   = 4,
    parameter int DW      = 6,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NPROC-1:0]    i_req,
    input  logic [NPROC*DW-1:0] i_req_data,
    input  logic [NPROC-1:0]    i_done,
    output logic [NPROC-1:0]    o_gnt,
    output logic [DW-1:0]       o_out,
    output logic                o_out_valid,
    output logic                o_err,
    output logic                o_busy
);

    localparam int IW = (NPROC > 1) ? $clog2(NPROC) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_win;
    logic [IW-1:0]   r_last;
    logic [7:0]      r_tcnt;

    logic [IW-1:0]   w_pick;
    logic [IW-1:0]   w_idx;
    logic            w_win_done;
    logic            w_win_req;
    logic [DW-1:0]   w_win_data;
    logic [NPROC-1:0] w_onehot;

    // Scan from the farthest offset down to the nearest so the last hit is
    // the first requester after r_last in round-robin order.
    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        for (int off = NPROC; off >= 1; off--) begin
            w_idx = IW'((int'(r_last) + off) % NPROC);
            if (i_req[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    assign w_win_done = i_done[r_win];
    assign w_win_req  = i_req[r_win];
    assign w_win_data = i_req_data[int'(r_win)*DW +: DW];
    assign w_onehot   = {{(NPROC-1){1'b0}}, 1'b1} << w_pick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_win       <= '0;
            r_last      <= IW'(NPROC-1);
            r_tcnt      <= '0;
            o_gnt       <= '0;
            o_out       <= '0;
            o_out_valid <= 1'b0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_out_valid <= 1'b0;
            o_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|i_req) begin
                        r_win   <= w_pick;
                        o_gnt   <= w_onehot;
                        o_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_tcnt <= '0;
                    // A done coinciding with the grant cycle is accepted as if in BUSY.
                    if (w_win_done) begin
                        o_out       <= w_win_data;
                        o_out_valid <= 1'b1;
                        o_gnt       <= '0;
                        r_state     <= S_RELEASE;
                    end else begin
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_win_done) begin
                        o_out       <= w_win_data;
                        o_out_valid <= 1'b1;
                        o_gnt       <= '0;
                        r_state     <= S_RELEASE;
                    end else if (!w_win_req) begin
                        o_gnt   <= '0;
                        r_state <= S_RELEASE;
                    end else if (r_tcnt == 8'(TIMEOUT-1)) begin
                        o_err   <= 1'b1;
                        o_gnt   <= '0;
                        r_state <= S_RELEASE;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_RELEASE: begin
                    r_last  <= r_win;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_gnt   <= '0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_sched_arbiter.sv
module tb_proc_sched_arbiter;

    localparam int NPROC   = 4;
    localparam int DW      = 6;
    localparam int TIMEOUT = 15;

    logic                clk;
    logic                rst_n;
    logic [NPROC-1:0]    i_req;
    logic [NPROC*DW-1:0] i_req_data;
    logic [NPROC-1:0]    i_done;
    logic [NPROC-1:0]    o_gnt;
    logic [DW-1:0]       o_out;
    logic                o_out_valid;
    logic                o_err;
    logic                o_busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: who was served last, and what out should hold.
    int          model_last;
    logic [DW-1:0] model_out;

    proc_sched_arbiter #(.NPROC(NPROC), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_req_data (i_req_data),
        .i_done     (i_done),
        .o_gnt      (o_gnt),
        .o_out      (o_out),
        .o_out_valid(o_out_valid),
        .o_err      (o_err),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // First requester after 'last' in circular order.
    function automatic int rr_pick(input logic [NPROC-1:0] rq, input int last);
        for (int off = 1; off <= NPROC; off++) begin
            if (rq[(last + off) % NPROC]) return (last + off) % NPROC;
        end
        return -1;
    endfunction

    task automatic apply_reset;
        rst_n      = 1'b0;
        i_req      = '0;
        i_done     = '0;
        i_req_data = '0;
        tick;
        tick;
        rst_n      = 1'b1;
        model_last = NPROC - 1;
        model_out  = '0;
        tick;
    endtask

    // One complete grant: mode 0 = done after d cycles, 1 = request drop
    // after d cycles, 2 = stall until timeout.
    task automatic do_grant(input logic [NPROC-1:0] rq, input int mode, input int d,
                            input logic [DW-1:0] val, input string name);
        int               k;
        logic [NPROC-1:0] eg;
        k  = rr_pick(rq, model_last);
        eg = NPROC'(1) << k;
        i_req = rq;
        tick;
        total++;
        if (o_gnt !== eg || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s grant got gnt=%b busy=%b exp gnt=%b busy=1", name, o_gnt, o_busy, eg);
        end
        for (int c = 0; c < ((mode == 2) ? TIMEOUT : d); c++) begin
            i_done     = NPROC'($urandom) & ~eg;
            i_req      = NPROC'($urandom) | eg;
            i_req_data = (NPROC*DW)'($urandom);
            tick;
            total++;
            if (o_out_valid !== 1'b0 || o_err !== 1'b0 || o_gnt !== eg) begin
                bad++;
                $display("FAIL %s hold c=%0d got valid=%b err=%b gnt=%b exp 0 0 %b",
                         name, c, o_out_valid, o_err, o_gnt, eg);
            end
        end
        if (mode == 0) begin
            i_req_data = (NPROC*DW)'($urandom);
            i_req_data[k*DW +: DW] = val;
            i_done = (NPROC'($urandom) & ~eg) | eg;
            model_out = val;
        end else if (mode == 1) begin
            i_done = NPROC'($urandom) & ~eg;
            i_req  = NPROC'($urandom) & ~eg;
        end else begin
            i_done = NPROC'($urandom) & ~eg;
        end
        tick;
        i_done = '0;
        total++;
        if (o_out_valid !== (mode == 0) || o_err !== (mode == 2) ||
            o_out !== model_out || o_gnt !== '0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s release got valid=%b err=%b out=%0d gnt=%b busy=%b exp valid=%0d err=%0d out=%0d gnt=0 busy=1",
                     name, o_out_valid, o_err, o_out, o_gnt, o_busy, (mode == 0), (mode == 2), model_out);
        end
        i_req = '0;
        tick;
        total++;
        if (o_out_valid !== 1'b0 || o_err !== 1'b0 || o_busy !== 1'b0 ||
            o_gnt !== '0 || o_out !== model_out) begin
            bad++;
            $display("FAIL %s idle got valid=%b err=%b busy=%b gnt=%b out=%0d exp 0 0 0 0 out=%0d",
                     name, o_out_valid, o_err, o_busy, o_gnt, o_out, model_out);
        end
        model_last = k;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        i_req = '1;
        i_done = '1;
        i_req_data = '1;
        #3;
        total++;
        if (o_gnt !== '0 || o_out !== '0 || o_out_valid !== 1'b0 || o_err !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset got gnt=%b out=%0d valid=%b err=%b busy=%b exp all 0",
                     o_gnt, o_out, o_out_valid, o_err, o_busy);
        end
        apply_reset;
        total++;
        if (o_gnt !== '0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got gnt=%b busy=%b exp 0 0", o_gnt, o_busy);
        end
    endtask

    task automatic test_single;
        do_grant(4'b0001, 0, 3, 6'd30, "single");
    endtask

    task automatic test_back_to_back;
        int               k;
        logic [NPROC-1:0] eg;
        logic [DW-1:0]    ev;
        apply_reset;
        for (int i = 0; i < NPROC; i++) i_req_data[i*DW +: DW] = DW'(10 + i);
        i_req = '1;
        for (int g = 0; g < 5; g++) begin
            k  = rr_pick(i_req, model_last);
            eg = NPROC'(1) << k;
            ev = DW'(10 + k);
            tick;
            total++;
            if (o_gnt !== eg) begin
                bad++;
                $display("FAIL b2b grant g=%0d got=%b exp=%b", g, o_gnt, eg);
            end
            tick;
            i_done = eg;
            tick;
            i_done = '0;
            total++;
            if (o_out_valid !== 1'b1 || o_out !== ev || o_gnt !== '0) begin
                bad++;
                $display("FAIL b2b out g=%0d got valid=%b out=%0d gnt=%b exp 1 %0d 0",
                         g, o_out_valid, o_out, o_gnt, ev);
            end
            model_out  = ev;
            model_last = k;
            if (g == 4) i_req = '0;
            tick;
            total++;
            if (o_gnt !== '0 || o_out_valid !== 1'b0 || o_busy !== 1'b0) begin
                bad++;
                $display("FAIL b2b idle g=%0d got gnt=%b valid=%b busy=%b exp 0 0 0",
                         g, o_gnt, o_out_valid, o_busy);
            end
        end
        total++;
        if (model_last !== 0) begin
            bad++;
            $display("FAIL b2b order last got=%0d exp=0", model_last);
        end
    endtask

    task automatic test_foreign_done;
        i_req = 4'b0010;
        tick;
        total++;
        if (o_gnt !== 4'b0010) begin
            bad++;
            $display("FAIL foreign grant got=%b exp=0010", o_gnt);
        end
        tick;
        i_req_data = '0;
        i_req_data[2*DW +: DW] = 6'd41;
        i_done = 4'b0100;
        tick;
        i_done = '0;
        total++;
        if (o_out_valid !== 1'b0 || o_gnt !== 4'b0010 || o_out !== model_out) begin
            bad++;
            $display("FAIL foreign ignored got valid=%b gnt=%b out=%0d exp 0 0010 %0d",
                     o_out_valid, o_gnt, o_out, model_out);
        end
        i_req_data[1*DW +: DW] = 6'd5;
        i_done = 4'b0010;
        tick;
        i_done = '0;
        total++;
        if (o_out_valid !== 1'b1 || o_out !== 6'd5) begin
            bad++;
            $display("FAIL foreign own got valid=%b out=%0d exp 1 5", o_out_valid, o_out);
        end
        model_out  = 6'd5;
        model_last = 1;
        i_req = '0;
        tick;
    endtask

    task automatic test_req_drop_wrap;
        do_grant(4'b1000, 1, 2, '0, "drop");
        do_grant(4'b1001, 0, 1, 6'd17, "wrap");
        total++;
        if (model_last !== 0) begin
            bad++;
            $display("FAIL wrap winner got=%0d exp=0", model_last);
        end
    endtask

    task automatic test_timeout;
        do_grant(4'b0100, 2, 0, '0, "timeout");
    endtask

    task automatic test_random;
        logic [NPROC-1:0] rq;
        int               mode;
        for (int it = 0; it < 40; it++) begin
            rq   = NPROC'($urandom_range(1, (1 << NPROC) - 1));
            mode = $urandom_range(0, 4);
            if (mode > 2) mode = 0;
            if (mode == 0)
                do_grant(rq, 0, $urandom_range(0, TIMEOUT), DW'($urandom), "rand_done");
            else if (mode == 1)
                do_grant(rq, 1, $urandom_range(1, 10), '0, "rand_drop");
            else
                do_grant(rq, 2, 0, '0, "rand_tmo");
        end
    endtask

    task automatic test_reset_mid_busy;
        do_grant(4'b0001, 0, 1, 6'h2A, "pre_rst");
        i_req = 4'b0100;
        tick;
        tick;
        tick;
        #2;
        i_done = 4'b0100;
        rst_n  = 1'b0;
        #1;
        total++;
        if (o_gnt !== '0 || o_out !== '0 || o_out_valid !== 1'b0 || o_err !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid got gnt=%b out=%0d valid=%b err=%b busy=%b exp all 0",
                     o_gnt, o_out, o_out_valid, o_err, o_busy);
        end
        tick;
        i_done     = '0;
        i_req      = '0;
        rst_n      = 1'b1;
        model_last = NPROC - 1;
        model_out  = '0;
        tick;
        total++;
        if (o_out_valid !== 1'b0 || o_out !== '0) begin
            bad++;
            $display("FAIL rst_after got valid=%b out=%0d exp 0 0", o_out_valid, o_out);
        end
        do_grant(4'b1111, 0, 1, 6'd7, "rst_first");
        total++;
        if (model_last !== 0) begin
            bad++;
            $display("FAIL rst_first winner got=%0d exp=0", model_last);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_foreign_done;
        test_req_drop_wrap;
        test_timeout;
        test_random;
        test_reset_mid_busy;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
